// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// operation encodings, FSM states and the default operand width.
package mdu_pkg;

  localparam int MDU_WIDTH = 32;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10
  } state_e;

  function automatic logic op_is_div(input md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic op_is_signed(input md_op_e op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One combinational restoring-division step: shift the next dividend bit
// into the partial remainder, subtract the divisor, keep it if no borrow.
module mdu_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quot,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quot_next
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    shifted = {rem, quot[WIDTH-1]};
    diff    = shifted - {1'b0, divisor};
    // A set top bit of diff is the borrow: restore the shifted remainder.
    if (diff[WIDTH]) begin
      rem_next  = shifted[WIDTH-1:0];
      quot_next = {quot[WIDTH-2:0], 1'b0};
    end else begin
      rem_next  = diff[WIDTH-1:0];
      quot_next = {quot[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/mdu.sv
// Iterative MIPS multiply/divide unit holding HI/LO: radix-2 shift-add
// multiply and restoring divide sharing one 2*WIDTH accumulator.
module mdu
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       md_op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_e             state, next_state;
  logic [CNT_W-1:0]   count;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH-1:0]   dividend_raw;
  logic               is_div, div_zero, neg_main, neg_rem;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   div_rem_next, div_quot_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  always_comb begin
    a_neg   = op_is_signed(md_op_e'(md_op)) && a_in[WIDTH-1];
    b_neg   = op_is_signed(md_op_e'(md_op)) && b_in[WIDTH-1];
    a_mag   = a_neg ? -a_in : a_in;
    b_mag   = b_neg ? -b_in : b_in;
    addend  = acc[0] ? opnd : '0;
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    // Signs were stripped on accept; restore them only at writeback.
    prod_fix = neg_main ? -acc : acc;
    quot_fix = neg_main ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem       (acc[2*WIDTH-1:WIDTH]),
    .quot      (acc[WIDTH-1:0]),
    .divisor   (opnd),
    .rem_next  (div_rem_next),
    .quot_next (div_quot_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (start) next_state = S_CALC;
      S_CALC:  if (count == LAST_ITER) next_state = S_FIX;
      S_FIX:   next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // The accumulator holds {partial product, multiplier} for multiply and
  // {partial remainder, dividend/quotient} for divide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy         <= 1'b0;
      done         <= 1'b0;
      hi_out       <= '0;
      lo_out       <= '0;
      count        <= '0;
      acc          <= '0;
      opnd         <= '0;
      dividend_raw <= '0;
      is_div       <= 1'b0;
      div_zero     <= 1'b0;
      neg_main     <= 1'b0;
      neg_rem      <= 1'b0;
    end else begin
      busy <= (next_state != S_IDLE);
      done <= (state == S_FIX);
      case (state)
        S_IDLE: begin
          if (start) begin
            is_div       <= op_is_div(md_op_e'(md_op));
            neg_main     <= a_neg ^ b_neg;
            neg_rem      <= a_neg;
            div_zero     <= (b_in == '0);
            dividend_raw <= a_in;
            opnd         <= op_is_div(md_op_e'(md_op)) ? b_mag : a_mag;
            acc          <= op_is_div(md_op_e'(md_op)) ? {{WIDTH{1'b0}}, a_mag}
                                                       : {{WIDTH{1'b0}}, b_mag};
            count        <= '0;
          end else begin
            if (hi_we) hi_out <= wdata;
            if (lo_we) lo_out <= wdata;
          end
        end
        S_CALC: begin
          acc   <= is_div ? {div_rem_next, div_quot_next}
                          : {mul_sum, acc[WIDTH-1:1]};
          count <= count + CNT_W'(1);
        end
        S_FIX: begin
          if (!is_div) begin
            hi_out <= prod_fix[2*WIDTH-1:WIDTH];
            lo_out <= prod_fix[WIDTH-1:0];
          end else if (div_zero) begin
            hi_out <= dividend_raw;
            lo_out <= '1;
          end else begin
            hi_out <= rem_fix;
            lo_out <= quot_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
